// File: rtl/hazard5_bus_arbiter.sv
// Merges the Hazard5 fetch (I) and load/store (D) bus ports onto one AHB-Lite master.
// Handshake: an address phase transfers on a cycle with *_aph_req && *_aph_ready; requesters hold their fields until then.
module hazard5_bus_arbiter #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Fetch port
  input  logic              i_aph_req,
  input  logic              i_aph_panic,
  input  logic [W_ADDR-1:0] i_haddr,
  input  logic [2:0]        i_hsize,
  output logic              i_aph_ready,
  output logic              i_dph_ready,
  output logic              i_dph_err,
  output logic [W_DATA-1:0] i_rdata,
  // Load/store port
  input  logic              d_aph_req,
  input  logic [W_ADDR-1:0] d_haddr,
  input  logic [2:0]        d_hsize,
  input  logic              d_hwrite,
  input  logic [W_DATA-1:0] d_wdata,
  output logic              d_aph_ready,
  output logic              d_dph_ready,
  output logic              d_dph_err,
  output logic [W_DATA-1:0] d_rdata,
  // AHB-Lite master
  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  input  logic              hready,
  input  logic              hresp,
  output logic [W_DATA-1:0] hwdata,
  input  logic [W_DATA-1:0] hrdata,
  // Debug: {aph_lock, aph_lock_sel, dph_own}
  output logic [3:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } own_t;

  own_t r_dph_own;
  own_t w_dph_own_nxt;
  logic r_aph_lock;
  logic r_aph_lock_sel;
  logic w_aph_lock_nxt;
  logic w_aph_lock_sel_nxt;
  logic w_gnt_d;
  logic w_gnt_i;
  logic w_sel_d;
  logic w_sel_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aph_lock     <= 1'b0;
      r_aph_lock_sel <= 1'b0;
      r_dph_own      <= OWN_NONE;
    end else begin
      r_aph_lock     <= w_aph_lock_nxt;
      r_aph_lock_sel <= w_aph_lock_sel_nxt;
      r_dph_own      <= w_dph_own_nxt;
    end
  end

  always_comb begin
    w_gnt_d            = d_aph_req && !(i_aph_req && i_aph_panic);
    w_gnt_i            = i_aph_req && !w_gnt_d;
    w_sel_d            = w_gnt_d;
    w_sel_i            = w_gnt_i;
    w_aph_lock_nxt     = r_aph_lock;
    w_aph_lock_sel_nxt = r_aph_lock_sel;
    w_dph_own_nxt      = r_dph_own;

    // A stalled address phase must not change under the slave's feet.
    if (r_aph_lock) begin
      w_sel_d = r_aph_lock_sel;
      w_sel_i = !r_aph_lock_sel;
    end

    if (hready) begin
      w_aph_lock_nxt = 1'b0;
      if (w_sel_d)      w_dph_own_nxt = OWN_D;
      else if (w_sel_i) w_dph_own_nxt = OWN_I;
      else              w_dph_own_nxt = OWN_NONE;
    end else if (w_sel_d || w_sel_i) begin
      w_aph_lock_nxt     = 1'b1;
      w_aph_lock_sel_nxt = w_sel_d;
    end
  end

  assign haddr     = w_sel_d ? d_haddr : i_haddr;
  assign hsize     = w_sel_d ? d_hsize : i_hsize;
  assign hwrite    = w_sel_d && d_hwrite;
  assign hprot     = w_sel_d ? 4'b0011 : 4'b0010;
  assign htrans    = (w_sel_d || w_sel_i) ? 2'b10 : 2'b00;
  assign hburst    = 3'b000;
  assign hmastlock = 1'b0;
  assign hwdata    = d_wdata;

  assign i_aph_ready = hready && w_sel_i;
  assign d_aph_ready = hready && w_sel_d;
  assign i_dph_ready = hready && (r_dph_own == OWN_I);
  assign d_dph_ready = hready && (r_dph_own == OWN_D);
  assign i_dph_err   = i_dph_ready && hresp;
  assign d_dph_err   = d_dph_ready && hresp;
  assign i_rdata     = hrdata;
  assign d_rdata     = hrdata;

  assign o_dbg_state = {r_aph_lock, r_aph_lock_sel, r_dph_own};

endmodule
